// File: rtl/barrel_shifter_pipe.sv
// barrel_shifter_pipe
//   Pipelined ARM-style barrel shifter (LSL, LSR, ASR, ROR, RRX) with shifter
//   carry-out. It supports immediate and register-specified amounts, and has
//   valid/ready handshakes on both sides.
//   The shift and carry are computed combinationally in front of slot 0.
//   Slots 1..STAGES-1 only carry the finished result downstream.
//   Results are therefore bit-identical for every STAGES value.
// Ports
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_ready   input handshake
//   in_type             00 LSL, 01 LSR, 10 ASR, 11 ROR (RRX for immediate #0)
//   in_by_reg           1: 8-bit register amount, 0: immediate encoding
//   in_amount           shift amount
//   in_op, in_carry     operand and current C flag
//   out_valid/out_ready output handshake
//   out_result          shifted value
//   out_carry           shifter carry-out
module barrel_shifter_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_type,
  input  logic             in_by_reg,
  input  logic [7:0]       in_amount,
  input  logic [WIDTH-1:0] in_op,
  input  logic             in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry
);

  localparam logic [7:0] AMASK = 8'(WIDTH - 1);
  localparam logic [8:0] W9    = 9'(WIDTH);

  logic [7:0]       m, k, km1;
  logic [WIDTH-1:0] t_r, t_l, r_lsl, r_lsr, r_asr, r_ror;
  logic             sign, amt_lt_w, amt_eq_w;
  logic [WIDTH-1:0] sh_res;
  logic             sh_car;

  // k is the distance used by the ordinary (non-special) shift cases.
  // Immediate amounts and register-mode ROR both reduce modulo WIDTH.
  // The bit shifted out last sits at position k-1 (right shifts) or
  // WIDTH-k (left shift). That bit is exposed by shifting k-1 places.
  always_comb begin
    m        = in_amount & AMASK;
    k        = (in_by_reg && in_type != 2'b11) ? in_amount : m;
    km1      = k - 8'd1;
    t_r      = in_op >> km1;
    t_l      = in_op << km1;
    r_lsl    = in_op << k;
    r_lsr    = in_op >> k;
    r_asr    = $signed(in_op) >>> k;
    r_ror    = (in_op >> k) | (in_op << (W9 - {1'b0, k}));
    sign     = in_op[WIDTH-1];
    amt_lt_w = {1'b0, in_amount} < W9;
    amt_eq_w = {1'b0, in_amount} == W9;
    sh_res   = in_op;
    sh_car   = in_carry;
    if (!in_by_reg) begin
      case (in_type)
        2'b00: begin
          if (k != 8'd0) begin
            sh_res = r_lsl;
            sh_car = t_l[WIDTH-1];
          end
        end
        2'b01: begin
          if (k == 8'd0) begin
            sh_res = '0;
            sh_car = sign;
          end else begin
            sh_res = r_lsr;
            sh_car = t_r[0];
          end
        end
        2'b10: begin
          if (k == 8'd0) begin
            sh_res = {WIDTH{sign}};
            sh_car = sign;
          end else begin
            sh_res = r_asr;
            sh_car = t_r[0];
          end
        end
        default: begin
          if (k == 8'd0) begin
            sh_res = {in_carry, in_op[WIDTH-1:1]};
            sh_car = in_op[0];
          end else begin
            sh_res = r_ror;
            sh_car = t_r[0];
          end
        end
      endcase
    end else if (in_amount != 8'd0) begin
      case (in_type)
        2'b00: begin
          sh_res = amt_lt_w ? r_lsl : '0;
          sh_car = amt_lt_w ? t_l[WIDTH-1] : (amt_eq_w & in_op[0]);
        end
        2'b01: begin
          sh_res = amt_lt_w ? r_lsr : '0;
          sh_car = amt_lt_w ? t_r[0] : (amt_eq_w & sign);
        end
        2'b10: begin
          sh_res = amt_lt_w ? r_asr : {WIDTH{sign}};
          sh_car = amt_lt_w ? t_r[0] : sign;
        end
        default: begin
          // A multiple of WIDTH leaves the value unchanged.
          // The carry is then the top bit.
          sh_res = (k == 8'd0) ? in_op : r_ror;
          sh_car = (k == 8'd0) ? sign : t_r[0];
        end
      endcase
    end
  end

  logic             slot_vld [STAGES];
  logic [WIDTH-1:0] slot_res [STAGES];
  logic             slot_car [STAGES];
  logic             src_vld  [STAGES];
  logic [WIDTH-1:0] src_res  [STAGES];
  logic             src_car  [STAGES];
  logic             load     [STAGES];

  always_comb begin
    src_vld[0] = in_valid;
    src_res[0] = sh_res;
    src_car[0] = sh_car;
    for (int i = 1; i < STAGES; i++) begin
      src_vld[i] = slot_vld[i-1];
      src_res[i] = slot_res[i-1];
      src_car[i] = slot_car[i-1];
    end
  end

  // A slot may load when it is empty or when its occupant leaves this cycle.
  // The chain runs back from out_ready, so bubbles collapse.
  always_comb begin
    logic chain;
    chain = !slot_vld[STAGES-1] || out_ready;
    load[STAGES-1] = chain;
    for (int i = STAGES - 2; i >= 0; i--) begin
      chain   = !slot_vld[i] || chain;
      load[i] = chain;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        slot_vld[i] <= 1'b0;
        slot_res[i] <= '0;
        slot_car[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (load[i]) begin
          slot_vld[i] <= src_vld[i];
          slot_res[i] <= src_res[i];
          slot_car[i] <= src_car[i];
        end
      end
    end
  end

  assign in_ready   = load[0];
  assign out_valid  = slot_vld[STAGES-1];
  assign out_result = slot_res[STAGES-1];
  assign out_carry  = slot_car[STAGES-1];

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
module tb_barrel_shifter_pipe;

  localparam int MW = 32;
  localparam int MS = 2;
  localparam int NV = 4;
  localparam int VW [NV] = '{8, 64, 8, 64};
  localparam int VS [NV] = '{1, 3, 3, 1};
  localparam int NP = 12;

  logic          clk, rst_n;
  logic          in_valid, in_ready, in_by_reg, in_carry;
  logic [1:0]    in_type;
  logic [7:0]    in_amount;
  logic [MW-1:0] in_op, out_result;
  logic          out_valid, out_ready, out_carry;

  logic          v_valid, v_by_reg, v_carry, v_out_ready;
  logic [1:0]    v_type;
  logic [7:0]    v_amount;
  logic [63:0]   v_op;
  logic          v_rdy [NV];
  logic          v_vld [NV];
  logic          v_car [NV];
  logic [63:0]   v_res [NV];

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]  ty;
    logic        br;
    logic [7:0]  amt;
    logic [31:0] op;
    logic        cin;
    logic [31:0] er;
    logic        ec;
  } vec_t;

  barrel_shifter_pipe #(.WIDTH(MW), .STAGES(MS)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_type(in_type), .in_by_reg(in_by_reg), .in_amount(in_amount),
    .in_op(in_op), .in_carry(in_carry),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_carry(out_carry)
  );

  for (genvar g = 0; g < NV; g++) begin : gv
    logic [VW[g]-1:0] r;
    barrel_shifter_pipe #(.WIDTH(VW[g]), .STAGES(VS[g])) u (
      .clk(clk), .rst_n(rst_n),
      .in_valid(v_valid), .in_ready(v_rdy[g]),
      .in_type(v_type), .in_by_reg(v_by_reg), .in_amount(v_amount),
      .in_op(v_op[VW[g]-1:0]), .in_carry(v_carry),
      .out_valid(v_vld[g]), .out_ready(v_out_ready),
      .out_result(r), .out_carry(v_car[g])
    );
    assign v_res[g] = 64'(r);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic bit_of(input logic [63:0] v, input int i);
    logic [63:0] t;
    t = v >> i;
    return t[0];
  endfunction

  // Bit-by-bit reference built directly from the shift definitions.
  function automatic void ref_shift(input int w, input logic [1:0] ty, input logic br,
                                    input int amt, input logic [63:0] op, input logic cin,
                                    output logic [63:0] r, output logic c);
    logic [63:0] o, mask;
    int n, m;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    o = op & mask;
    r = '0;
    c = cin;
    n = br ? amt : (amt % w);
    if (!br && n == 0 && ty == 2'd3) begin
      for (int i = 0; i < w - 1; i++) r |= 64'(bit_of(o, i + 1)) << i;
      r |= 64'(cin) << (w - 1);
      c = bit_of(o, 0);
      return;
    end
    if (!br && n == 0 && (ty == 2'd1 || ty == 2'd2)) n = w;
    if (n == 0) begin
      r = o;
      return;
    end
    case (ty)
      2'd0: begin
        for (int i = 0; i < w; i++) if (i >= n) r |= 64'(bit_of(o, i - n)) << i;
        c = (n <= w) ? bit_of(o, w - n) : 1'b0;
      end
      2'd1: begin
        for (int i = 0; i < w; i++) if (i + n < w) r |= 64'(bit_of(o, i + n)) << i;
        c = (n <= w) ? bit_of(o, n - 1) : 1'b0;
      end
      2'd2: begin
        for (int i = 0; i < w; i++)
          r |= 64'((i + n < w) ? bit_of(o, i + n) : bit_of(o, w - 1)) << i;
        c = (n <= w) ? bit_of(o, n - 1) : bit_of(o, w - 1);
      end
      default: begin
        m = n % w;
        for (int i = 0; i < w; i++) r |= 64'(bit_of(o, (i + m) % w)) << i;
        c = bit_of(o, (m + w - 1) % w);
      end
    endcase
  endfunction

  task automatic drive(input logic [1:0] ty, input logic br, input logic [7:0] amt,
                       input logic [31:0] op, input logic cin);
    in_type = ty; in_by_reg = br; in_amount = amt; in_op = op; in_carry = cin;
  endtask

  task automatic rand_vec(output vec_t v);
    logic [63:0] r;
    logic c;
    v.ty  = 2'($urandom_range(0, 3));
    v.br  = 1'($urandom_range(0, 1));
    v.amt = (v.br && $urandom_range(0, 3) != 0) ? 8'($urandom_range(0, 40))
                                                 : 8'($urandom_range(0, 255));
    v.op  = $urandom;
    v.cin = 1'($urandom_range(0, 1));
    ref_shift(MW, v.ty, v.br, int'(v.amt), {32'd0, v.op}, v.cin, r, c);
    v.er = r[31:0];
    v.ec = c;
  endtask

  // Sends one op into an empty pipe and waits (bounded) for its result.
  // lat is 0 if the result never appears.
  task automatic run_one(input vec_t v, output logic [31:0] r, output logic c, output int lat);
    @(negedge clk);
    drive(v.ty, v.br, v.amt, v.op, v.cin);
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0; r = '0; c = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k; r = out_result; c = out_carry;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (out_valid !== 1'b0 || out_result !== '0 || out_carry !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs valid=%b result=%h carry=%b expected 0/0/0",
               out_valid, out_result, out_carry);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%b expected=1", in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_imm();
    vec_t tv [10];
    logic [31:0] r;
    logic c;
    int lat;
    tv = '{
      '{2'd0, 1'b0, 8'd4,   32'h8000000F, 1'b0, 32'h000000F0, 1'b0},
      '{2'd0, 1'b0, 8'd1,   32'h80000001, 1'b0, 32'h00000002, 1'b1},
      '{2'd0, 1'b0, 8'd0,   32'h12345678, 1'b1, 32'h12345678, 1'b1},
      '{2'd1, 1'b0, 8'd0,   32'h80000000, 1'b0, 32'h00000000, 1'b1},
      '{2'd2, 1'b0, 8'd0,   32'h80000000, 1'b0, 32'hFFFFFFFF, 1'b1},
      '{2'd3, 1'b0, 8'd0,   32'h00000003, 1'b1, 32'h80000001, 1'b1},
      '{2'd2, 1'b0, 8'd4,   32'h80000010, 1'b0, 32'hF8000001, 1'b0},
      '{2'd3, 1'b0, 8'd8,   32'h12345678, 1'b1, 32'h78123456, 1'b0},
      '{2'd1, 1'b0, 8'h24,  32'h000000F8, 1'b0, 32'h0000000F, 1'b1},
      '{2'd0, 1'b0, 8'h20,  32'h00000005, 1'b1, 32'h00000005, 1'b1}
    };
    for (int i = 0; i < 10; i++) begin
      run_one(tv[i], r, c, lat);
      checks++;
      if (r !== tv[i].er || c !== tv[i].ec) begin
        failures++;
        $display("FAIL imm[%0d] result=%h carry=%b expected result=%h carry=%b",
                 i, r, c, tv[i].er, tv[i].ec);
      end
      checks++;
      if (lat != MS) begin
        failures++;
        $display("FAIL imm_latency[%0d] got=%0d expected=%0d", i, lat, MS);
      end
    end
  endtask

  task automatic test_reg();
    vec_t tv [12];
    logic [31:0] r;
    logic c;
    int lat;
    tv = '{
      '{2'd0, 1'b1, 8'd32,  32'h00000001, 1'b0, 32'h00000000, 1'b1},
      '{2'd0, 1'b1, 8'd33,  32'h00000001, 1'b1, 32'h00000000, 1'b0},
      '{2'd3, 1'b1, 8'd32,  32'h80000000, 1'b0, 32'h80000000, 1'b1},
      '{2'd3, 1'b1, 8'd36,  32'h00000010, 1'b1, 32'h00000001, 1'b0},
      '{2'd1, 1'b1, 8'd0,   32'hABCD1234, 1'b1, 32'hABCD1234, 1'b1},
      '{2'd1, 1'b1, 8'd32,  32'h80000000, 1'b0, 32'h00000000, 1'b1},
      '{2'd1, 1'b1, 8'd40,  32'h80000000, 1'b1, 32'h00000000, 1'b0},
      '{2'd2, 1'b1, 8'd200, 32'h80000000, 1'b0, 32'hFFFFFFFF, 1'b1},
      '{2'd2, 1'b1, 8'd255, 32'h7FFFFFFF, 1'b1, 32'h00000000, 1'b0},
      '{2'd0, 1'b1, 8'd31,  32'h00000003, 1'b0, 32'h80000000, 1'b1},
      '{2'd3, 1'b1, 8'd0,   32'h00000003, 1'b0, 32'h00000003, 1'b0},
      '{2'd1, 1'b1, 8'd1,   32'h00000001, 1'b0, 32'h00000000, 1'b1}
    };
    for (int i = 0; i < 12; i++) begin
      run_one(tv[i], r, c, lat);
      checks++;
      if (r !== tv[i].er || c !== tv[i].ec || lat == 0) begin
        failures++;
        $display("FAIL reg[%0d] result=%h carry=%b lat=%0d expected result=%h carry=%b",
                 i, r, c, lat, tv[i].er, tv[i].ec);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t sv [8];
    int sent, got, first, last;
    for (int i = 0; i < 8; i++) rand_vec(sv[i]);
    sent = 0; got = 0; first = -1; last = -1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      @(negedge clk);
      in_valid = (sent < 8);
      if (sent < 8) drive(sv[sent].ty, sv[sent].br, sv[sent].amt, sv[sent].op, sv[sent].cin);
      #1;
      if (out_valid) begin
        checks++;
        if (out_result !== sv[got].er || out_carry !== sv[got].ec) begin
          failures++;
          $display("FAIL stream[%0d] result=%h carry=%b expected result=%h carry=%b",
                   got, out_result, out_carry, sv[got].er, sv[got].ec);
        end
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0;
    checks++;
    if (first != MS) begin
      failures++;
      $display("FAIL stream_latency got=%0d expected=%0d", first, MS);
    end
    checks++;
    if (got != 8 || last - first != 7) begin
      failures++;
      $display("FAIL stream_rate results=%0d span=%0d expected 8 results span 7", got, last - first);
    end
  endtask

  task automatic test_backpressure();
    localparam int N = 14;
    vec_t bv [N];
    int sent, got, acc_stall;
    logic have_held, held_c;
    logic [31:0] held_r;
    for (int i = 0; i < N; i++) rand_vec(bv[i]);
    sent = 0; got = 0; acc_stall = 0; have_held = 1'b0; held_r = '0; held_c = 1'b0;
    for (int cyc = 0; cyc < 80 && got < N; cyc++) begin
      @(negedge clk);
      out_ready = !((cyc < 5) || (cyc >= 12 && cyc < 17));
      in_valid = (sent < N);
      if (sent < N) drive(bv[sent].ty, bv[sent].br, bv[sent].amt, bv[sent].op, bv[sent].cin);
      #1;
      if (cyc == 4) begin
        checks++;
        if (acc_stall != MS || in_ready !== 1'b0) begin
          failures++;
          $display("FAIL bp_fill accepts=%0d in_ready=%b expected accepts=%0d in_ready=0",
                   acc_stall, in_ready, MS);
        end
      end
      if (cyc == 5) begin
        checks++;
        if (in_ready !== 1'b1) begin
          failures++;
          $display("FAIL bp_full_pass in_ready=%b expected=1", in_ready);
        end
      end
      if (out_valid) begin
        if (have_held) begin
          checks++;
          if (out_result !== held_r || out_carry !== held_c) begin
            failures++;
            $display("FAIL bp_stable result=%h carry=%b expected result=%h carry=%b",
                     out_result, out_carry, held_r, held_c);
          end
        end
        if (out_ready) begin
          checks++;
          if (out_result !== bv[got].er || out_carry !== bv[got].ec) begin
            failures++;
            $display("FAIL bp_order[%0d] result=%h carry=%b expected result=%h carry=%b",
                     got, out_result, out_carry, bv[got].er, bv[got].ec);
          end
          got++;
          have_held = 1'b0;
        end else begin
          held_r = out_result; held_c = out_carry; have_held = 1'b1;
        end
      end
      if (in_valid && in_ready) begin
        sent++;
        if (cyc < 5) acc_stall++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (got != N) begin
      failures++;
      $display("FAIL bp_count got=%0d expected=%0d", got, N);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL bp_no_dup out_valid=%b expected=0", out_valid);
      end
    end
  endtask

  task automatic test_reset_inflight();
    int stale;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1;
    drive(2'd0, 1'b0, 8'd1, 32'h11111111, 1'b0);
    @(negedge clk);
    drive(2'd1, 1'b0, 8'd2, 32'h22222222, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre out_valid=%b expected=1", out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_result !== '0 || out_carry !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_async valid=%b result=%h carry=%b in_ready=%b expected 0/0/0/1",
               out_valid, out_result, out_carry, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    stale = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    checks++;
    if (stale != 0) begin
      failures++;
      $display("FAIL rst_stale got=%0d stale results expected=0", stale);
    end
  endtask

  task automatic test_params();
    logic [1:0]  ty [NP];
    logic        br [NP];
    logic [7:0]  am [NP];
    logic [63:0] op [NP];
    logic        ci [NP];
    logic [63:0] er [NV][NP];
    logic        ec [NV][NP];
    int got [NV];
    int first [NV];
    int sent;
    logic [63:0] r;
    logic c;
    for (int i = 0; i < NP; i++) begin
      ty[i] = 2'($urandom_range(0, 3));
      br[i] = 1'($urandom_range(0, 1));
      am[i] = (i % 3 == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 70));
      op[i] = {$urandom, $urandom};
      ci[i] = 1'($urandom_range(0, 1));
      for (int g = 0; g < NV; g++) begin
        ref_shift(VW[g], ty[i], br[i], int'(am[i]), op[i], ci[i], r, c);
        er[g][i] = r;
        ec[g][i] = c;
      end
    end
    for (int g = 0; g < NV; g++) begin
      got[g] = 0;
      first[g] = -1;
    end
    sent = 0;
    v_out_ready = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      v_valid = (sent < NP);
      if (sent < NP) begin
        v_type = ty[sent]; v_by_reg = br[sent]; v_amount = am[sent];
        v_op = op[sent]; v_carry = ci[sent];
      end
      #1;
      for (int g = 0; g < NV; g++) begin
        if (v_vld[g] && got[g] < NP) begin
          checks++;
          if (v_res[g] !== er[g][got[g]] || v_car[g] !== ec[g][got[g]]) begin
            failures++;
            $display("FAIL param_w%0d_s%0d[%0d] result=%h carry=%b expected result=%h carry=%b",
                     VW[g], VS[g], got[g], v_res[g], v_car[g], er[g][got[g]], ec[g][got[g]]);
          end
          if (first[g] < 0) first[g] = cyc;
          got[g]++;
        end
      end
      if (v_valid) sent++;
    end
    v_valid = 1'b0;
    for (int g = 0; g < NV; g++) begin
      checks++;
      if (got[g] != NP || first[g] != VS[g]) begin
        failures++;
        $display("FAIL param_w%0d_s%0d_flow results=%0d first=%0d expected results=%0d first=%0d",
                 VW[g], VS[g], got[g], first[g], NP, VS[g]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1;
    drive(2'd0, 1'b0, 8'd0, 32'd0, 1'b0);
    v_valid = 1'b0; v_out_ready = 1'b1; v_type = 2'd0; v_by_reg = 1'b0;
    v_amount = 8'd0; v_op = '0; v_carry = 1'b0;
    test_reset();
    test_imm();
    test_reg();
    test_back_to_back();
    test_backpressure();
    test_reset_inflight();
    test_params();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
